mips_mul_unit: RTL

- Parametrised, single-clock iterative multiply unit for the MIPS execute stage.
- Replaces the two-clock-domain arrangement (PLL-derived fast multiplier clock, system clock divided by 34). Runs on the system clock and stalls the pipeline until its product is ready.
- Adds three things: signed/unsigned mode, early termination on small multipliers, and a destination-register tag that travels with the result.

---
 rtl/mips_mul_unit_if.sv | 27 ++
 rtl/mips_mul_unit.sv | 129 ++++++++++++
 2 files changed

// File: rtl/mips_mul_unit_if.sv
// Request/result bundle between the MIPS execute stage and the iterative multiply unit.
// The master side issues the operation; the slave side is the multiplier.
interface mips_mul_unit_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 5
);
  logic                 St;
  logic                 SignedOp;
  logic [WIDTH-1:0]     Multiplicando;
  logic [WIDTH-1:0]     Multiplicador;
  logic [TAG_W-1:0]     TagIn;
  logic [2*WIDTH-1:0]   Produto;
  logic [TAG_W-1:0]     TagOut;
  logic                 Done;
  logic                 Busy;
  logic                 Stall;

  modport master (
    output St, SignedOp, Multiplicando, Multiplicador, TagIn,
    input  Produto, TagOut, Done, Busy, Stall
  );

  modport slave (
    input  St, SignedOp, Multiplicando, Multiplicador, TagIn,
    output Produto, TagOut, Done, Busy, Stall
  );
endinterface

// File: rtl/mips_mul_unit.sv
// Single-clock shift-add multiplier for the execute stage: signed/unsigned operands,
// optional early exit once the remaining multiplier bits are zero, rd tag carried to the result.
module mips_mul_unit #(
  parameter int WIDTH      = 16,
  parameter int EARLY_TERM = 1,
  parameter int TAG_W      = 5
) (
  input  logic          CLK,
  input  logic          RST,
  mips_mul_unit_if.slave bus
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_reg, state_next;
  logic [PW-1:0]      acc_reg, acc_next;
  logic [PW-1:0]      mcand_reg, mcand_next;
  logic [PW-1:0]      produto_reg, produto_next;
  logic [WIDTH-1:0]   mplier_reg, mplier_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic               neg_reg, neg_next;
  logic               done_reg, done_next;
  logic [TAG_W-1:0]   tag_reg, tag_next;
  logic [TAG_W-1:0]   tag_out_reg, tag_out_next;

  logic               accept;
  logic               last_iter;
  logic               early_hit;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   mplier_shift;
  logic [PW-1:0]      acc_sum;

  // Magnitudes fit in WIDTH unsigned bits, including the most negative value.
  assign mag_a = (bus.SignedOp && bus.Multiplicando[WIDTH-1]) ? -bus.Multiplicando : bus.Multiplicando;
  assign mag_b = (bus.SignedOp && bus.Multiplicador[WIDTH-1]) ? -bus.Multiplicador : bus.Multiplicador;

  assign accept       = bus.St && ((state_reg == IDLE) || (state_reg == DONE));
  assign mplier_shift = mplier_reg >> 1;
  assign acc_sum      = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

  generate
    if (EARLY_TERM != 0) begin : g_early
      assign early_hit = (mplier_shift == '0);
    end else begin : g_fixed
      assign early_hit = 1'b0;
    end
  endgenerate

  assign last_iter = (cnt_reg == CW'(WIDTH - 1)) || early_hit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      cnt_reg     <= '0;
      neg_reg     <= 1'b0;
      tag_reg     <= '0;
      produto_reg <= '0;
      tag_out_reg <= '0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      mcand_reg   <= mcand_next;
      mplier_reg  <= mplier_next;
      cnt_reg     <= cnt_next;
      neg_reg     <= neg_next;
      tag_reg     <= tag_next;
      produto_reg <= produto_next;
      tag_out_reg <= tag_out_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    mcand_next   = mcand_reg;
    mplier_next  = mplier_reg;
    cnt_next     = cnt_reg;
    neg_next     = neg_reg;
    tag_next     = tag_reg;
    produto_next = produto_reg;
    tag_out_next = tag_out_reg;
    done_next    = 1'b0;

    case (state_reg)
      IDLE, DONE: begin
        if (bus.St) begin
          acc_next    = '0;
          mcand_next  = {{WIDTH{1'b0}}, mag_a};
          mplier_next = mag_b;
          cnt_next    = '0;
          neg_next    = bus.SignedOp && (bus.Multiplicando[WIDTH-1] ^ bus.Multiplicador[WIDTH-1]);
          tag_next    = bus.TagIn;
          state_next  = CALC;
        end else begin
          state_next  = IDLE;
        end
      end
      CALC: begin
        acc_next    = acc_sum;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_shift;
        cnt_next    = cnt_reg + CW'(1);
        if (last_iter) begin
          // A zero magnitude negates to zero, so no separate zero case is needed.
          produto_next = neg_reg ? -acc_sum : acc_sum;
          tag_out_next = tag_reg;
          done_next    = 1'b1;
          state_next   = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.Produto = produto_reg;
  assign bus.TagOut  = tag_out_reg;
  assign bus.Done    = done_reg;
  assign bus.Busy    = (state_reg == CALC);
  assign bus.Stall   = accept || (state_reg == CALC);

endmodule
